// File: rtl/fpad_alu_pkg.sv
// Shared definitions for the bus-attached ALU: opcodes, register offsets,
// STATUS bit positions and the engine state/operation types.
package fpad_alu_pkg;

    // Opcodes carried in CMD[3:0]
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;

    // Register offsets from the window base
    localparam logic [2:0] OFF_A      = 3'd0;
    localparam logic [2:0] OFF_B      = 3'd1;
    localparam logic [2:0] OFF_CMD    = 3'd2;
    localparam logic [2:0] OFF_RES_LO = 3'd3;
    localparam logic [2:0] OFF_RES_HI = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam int unsigned REG_COUNT = 6;

    // STATUS bit indices
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_Z    = 3;
    localparam int ST_C    = 4;
    localparam int ST_N    = 5;
    localparam int ST_V    = 6;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_e;

    typedef enum logic {
        ENG_IDLE = 1'b0,
        ENG_ITER = 1'b1
    } eng_state_e;

endpackage

// File: rtl/bus_alu_muldiv_seq.sv
// Iterative unsigned multiply / restoring divide engine. One step per clock;
// the final step's value is presented on o_lo/o_hi while o_done is high so the
// caller can capture the result on the same edge that ends the operation.
module alu_muldiv_seq
    import fpad_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  md_op_e            i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_hi
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    eng_state_e          r_state;
    eng_state_e          w_state_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_opnd;
    md_op_e              r_op;

    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_trial;
    logic [DATA_W+1:0]   w_div_diff;
    logic [2*DATA_W-1:0] w_step;

    // Multiply step: conditionally add the multiplicand into the high half, then shift right
    assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(DATA_W+1){1'b0}});

    // Divide step: shift the next dividend bit into the partial remainder and trial-subtract
    assign w_trial    = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_div_diff = {1'b0, w_trial} - {2'b00, r_opnd};

    // Select the next accumulator value for the running operation
    always_comb begin
        w_step = r_acc;
        if (r_op == MD_MUL) begin
            w_step = {w_mul_sum, r_acc[DATA_W-1:1]};
        end else if (w_div_diff[DATA_W+1] == 1'b0) begin
            w_step = {w_div_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
        end else begin
            w_step = {w_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ENG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ENG_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ENG_ITER;
                end else begin
                    w_state_nxt = ENG_IDLE;
                end
            end
            ENG_ITER: begin
                o_busy = 1'b1;
                if (r_count == CNT_W'(1)) begin
                    o_done      = 1'b1;
                    w_state_nxt = ENG_IDLE;
                end else begin
                    w_state_nxt = ENG_ITER;
                end
            end
            default: begin
                w_state_nxt = ENG_IDLE;
            end
        endcase
    end

    assign o_lo = w_step[DATA_W-1:0];
    assign o_hi = w_step[2*DATA_W-1:DATA_W];

    // Working registers: load operands on start, advance one step per edge while iterating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
            r_acc   <= {(2*DATA_W){1'b0}};
            r_opnd  <= {DATA_W{1'b0}};
            r_op    <= MD_MUL;
        end else if (r_state == ENG_IDLE) begin
            if (i_start) begin
                r_count <= CNT_W'(DATA_W);
                r_acc   <= {{DATA_W{1'b0}}, i_a};
                r_opnd  <= i_b;
                r_op    <= i_op;
            end
        end else begin
            r_count <= r_count - CNT_W'(1);
            r_acc   <= w_step;
        end
    end

endmodule

// File: rtl/bus_alu.sv
// Bus-attached ALU: six-register window on the shared tri-state bus with
// single-cycle logic/arith/shift ops and an iterative MUL/DIV engine.
module bus_alu
    import fpad_alu_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(8'h10)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [ADDR_W-1:0] w_addr,
    inout  wire  [DATA_W-1:0] bus
);

    localparam int                SH_W     = $clog2(DATA_W);
    localparam int                MSB      = DATA_W - 1;
    localparam logic [ADDR_W-1:0] WIN_SPAN = ADDR_W'(REG_COUNT);

    logic [DATA_W-1:0] r_a, r_b, r_res_lo, r_res_hi;
    logic              r_done, r_err, r_z, r_c, r_n, r_v;
    logic              r_md_mul;

    // Address decode: subtraction wraps addresses below the base out of range
    logic [ADDR_W-1:0] w_woff_full, w_roff_full;
    logic [2:0]        w_woff, w_roff;
    logic              w_wr_hit, w_rd_hit;

    assign w_woff_full = w_addr - BASE_ADDR;
    assign w_roff_full = r_addr - BASE_ADDR;
    assign w_wr_hit    = (w_woff_full < WIN_SPAN);
    assign w_rd_hit    = (r_addr != {ADDR_W{1'b0}}) && (w_roff_full < WIN_SPAN);
    assign w_woff      = w_woff_full[2:0];
    assign w_roff      = w_roff_full[2:0];

    logic              w_busy, w_eng_done;
    logic [DATA_W-1:0] w_eng_lo, w_eng_hi;
    logic [3:0]        w_op;
    logic              w_cmd_wr, w_accept, w_busy_cmd;
    md_op_e            w_md_op;

    assign w_op       = bus[3:0];
    assign w_cmd_wr   = w_wr_hit && (w_woff == OFF_CMD);
    assign w_accept   = w_cmd_wr && !w_busy;
    assign w_busy_cmd = w_cmd_wr && w_busy;
    assign w_md_op    = (w_op == OP_DIV) ? MD_DIV : MD_MUL;

    // Single-cycle datapath building blocks
    logic [DATA_W:0]        w_add, w_sub, w_shl, w_shr;
    logic signed [DATA_W:0] w_asr;
    logic [SH_W-1:0]        w_sh;

    assign w_sh  = r_b[SH_W-1:0];
    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} - {1'b0, r_b};
    assign w_shl = {1'b0, r_a} << w_sh;
    assign w_shr = {r_a, 1'b0} >> w_sh;
    assign w_asr = $signed({r_a, 1'b0}) >>> w_sh;

    logic [DATA_W-1:0] w_nx_lo, w_nx_hi, w_flag_src;
    logic              w_nx_wres, w_nx_flags_we, w_zn_en;
    logic              w_nx_done, w_nx_err, w_nx_c, w_nx_v, w_nx_z, w_nx_n;
    logic              w_start;

    // Decode the command being accepted into result, flag and status updates
    always_comb begin
        w_nx_lo       = r_res_lo;
        w_nx_hi       = r_res_hi;
        w_nx_wres     = 1'b0;
        w_nx_flags_we = 1'b1;
        w_nx_done     = 1'b1;
        w_nx_err      = 1'b0;
        w_nx_c        = 1'b0;
        w_nx_v        = 1'b0;
        w_zn_en       = 1'b1;
        w_flag_src    = {DATA_W{1'b0}};
        w_start       = 1'b0;
        case (w_op)
            OP_NOP: begin
                w_nx_flags_we = 1'b0;
                w_nx_err      = r_err;
            end
            OP_ADD: begin
                w_nx_lo   = w_add[MSB:0];
                w_nx_hi   = {{(DATA_W-1){1'b0}}, w_add[DATA_W]};
                w_nx_wres = 1'b1;
                w_nx_c    = w_add[DATA_W];
                w_nx_v    = (r_a[MSB] == r_b[MSB]) && (w_add[MSB] != r_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                w_nx_lo   = w_sub[MSB:0];
                w_nx_hi   = {{(DATA_W-1){1'b0}}, w_sub[DATA_W]};
                w_nx_wres = (w_op == OP_SUB);
                w_nx_c    = w_sub[DATA_W];
                w_nx_v    = (r_a[MSB] != r_b[MSB]) && (w_sub[MSB] != r_a[MSB]);
            end
            OP_AND: begin
                w_nx_lo   = r_a & r_b;
                w_nx_hi   = {DATA_W{1'b0}};
                w_nx_wres = 1'b1;
            end
            OP_OR: begin
                w_nx_lo   = r_a | r_b;
                w_nx_hi   = {DATA_W{1'b0}};
                w_nx_wres = 1'b1;
            end
            OP_XOR: begin
                w_nx_lo   = r_a ^ r_b;
                w_nx_hi   = {DATA_W{1'b0}};
                w_nx_wres = 1'b1;
            end
            OP_NOT: begin
                w_nx_lo   = ~r_a;
                w_nx_hi   = {DATA_W{1'b0}};
                w_nx_wres = 1'b1;
            end
            OP_SHL: begin
                w_nx_lo   = w_shl[MSB:0];
                w_nx_hi   = {DATA_W{1'b0}};
                w_nx_wres = 1'b1;
                w_nx_c    = w_shl[DATA_W];
            end
            OP_SHR: begin
                w_nx_lo   = w_shr[DATA_W:1];
                w_nx_hi   = {DATA_W{1'b0}};
                w_nx_wres = 1'b1;
                w_nx_c    = w_shr[0];
            end
            OP_ASR: begin
                w_nx_lo   = w_asr[DATA_W:1];
                w_nx_hi   = {DATA_W{1'b0}};
                w_nx_wres = 1'b1;
                w_nx_c    = w_asr[0];
            end
            OP_MUL: begin
                w_start   = 1'b1;
                w_nx_done = 1'b0;
                w_zn_en   = 1'b0;
            end
            OP_DIV: begin
                if (r_b == {DATA_W{1'b0}}) begin
                    // Divide by zero finishes immediately with a saturated quotient
                    w_nx_lo   = {DATA_W{1'b1}};
                    w_nx_hi   = r_a;
                    w_nx_wres = 1'b1;
                    w_nx_err  = 1'b1;
                end else begin
                    w_start   = 1'b1;
                    w_nx_done = 1'b0;
                    w_zn_en   = 1'b0;
                end
            end
            default: begin
                w_nx_err = 1'b1;
                w_zn_en  = 1'b0;
            end
        endcase
        w_flag_src = w_nx_lo;
        w_nx_z     = w_zn_en && (w_flag_src == {DATA_W{1'b0}});
        w_nx_n     = w_zn_en && w_flag_src[MSB];
    end

    alu_muldiv_seq #(.DATA_W(DATA_W)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept && w_start),
        .i_op    (w_md_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_busy  (w_busy),
        .o_done  (w_eng_done),
        .o_lo    (w_eng_lo),
        .o_hi    (w_eng_hi)
    );

    // Operand registers: bus writes land only while the engine is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= {DATA_W{1'b0}};
            r_b <= {DATA_W{1'b0}};
        end else if (w_wr_hit && !w_busy) begin
            if (w_woff == OFF_A) begin
                r_a <= bus;
            end
            if (w_woff == OFF_B) begin
                r_b <= bus;
            end
        end
    end

    // Results and status: command accept, engine completion, and rejected busy commands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_lo <= {DATA_W{1'b0}};
            r_res_hi <= {DATA_W{1'b0}};
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_md_mul <= 1'b0;
        end else if (w_accept) begin
            r_done <= w_nx_done;
            r_err  <= w_nx_err;
            if (w_nx_wres) begin
                r_res_lo <= w_nx_lo;
                r_res_hi <= w_nx_hi;
            end
            if (w_nx_flags_we) begin
                r_z <= w_nx_z;
                r_c <= w_nx_c;
                r_n <= w_nx_n;
                r_v <= w_nx_v;
            end
            if (w_start) begin
                r_md_mul <= (w_md_op == MD_MUL);
            end
        end else begin
            if (w_busy_cmd) begin
                r_err <= 1'b1;
            end
            if (w_eng_done) begin
                r_res_lo <= w_eng_lo;
                r_res_hi <= w_eng_hi;
                r_done   <= 1'b1;
                r_z      <= (w_eng_lo == {DATA_W{1'b0}});
                r_c      <= r_md_mul && (w_eng_hi != {DATA_W{1'b0}});
                r_n      <= w_eng_lo[MSB];
                r_v      <= 1'b0;
            end
        end
    end

    // Read mux over the register window
    logic [DATA_W-1:0] w_status, w_rdata;

    always_comb begin
        w_status          = {DATA_W{1'b0}};
        w_status[ST_BUSY] = w_busy;
        w_status[ST_DONE] = r_done;
        w_status[ST_ERR]  = r_err;
        w_status[ST_Z]    = r_z;
        w_status[ST_C]    = r_c;
        w_status[ST_N]    = r_n;
        w_status[ST_V]    = r_v;
        case (w_roff)
            OFF_A:      w_rdata = r_a;
            OFF_B:      w_rdata = r_b;
            OFF_RES_LO: w_rdata = r_res_lo;
            OFF_RES_HI: w_rdata = r_res_hi;
            OFF_STATUS: w_rdata = w_status;
            default:    w_rdata = {DATA_W{1'b0}};
        endcase
    end

    assign bus = (w_rd_hit && !rst) ? w_rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_alu.sv
// Self-checking bench for bus_alu: directed scenarios plus randomized
// commands compared against an arithmetic reference model.
module tb_bus_alu;

    localparam int W    = 8;
    localparam int BASE = 8'h10;

    logic       clk;
    logic       rst;
    logic [7:0] r_addr;
    logic [7:0] w_addr;
    logic       tb_en;
    logic [7:0] tb_d;
    tri1  [7:0] bus;

    assign bus = tb_en ? tb_d : 8'bzzzz_zzzz;

    bus_alu #(.DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'h10)) dut (
        .clk    (clk),
        .rst    (rst),
        .r_addr (r_addr),
        .w_addr (w_addr),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int m_a, m_b, m_lo, m_hi;
    bit m_done, m_err, m_z, m_c, m_n, m_v;

    function automatic int to_signed8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic bit ovf8(input int s);
        return (s > 127) || (s < -128);
    endfunction

    function automatic int exp_status();
        return (int'(m_v) << 6) | (int'(m_n) << 5) | (int'(m_c) << 4) | (int'(m_z) << 3)
             | (int'(m_err) << 2) | (int'(m_done) << 1);
    endfunction

    function automatic bit is_iter(input int op);
        return (op == 10) || (op == 11 && m_b != 0);
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_lo = 0; m_hi = 0;
        m_done = 0; m_err = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
    endtask

    // Final architectural effect of an accepted command
    task automatic model_cmd(input int op);
        int a, b, sa, sb, sh, r, fsrc;
        bit zn;
        a = m_a; b = m_b; sa = to_signed8(a); sb = to_signed8(b); sh = b % 8;
        fsrc = 0; zn = 1;
        if (op == 0) begin
            m_done = 1;
            return;
        end
        m_err = 0; m_c = 0; m_v = 0;
        case (op)
            1: begin r = a + b; m_lo = r & 255; m_hi = r >> 8; m_c = (r > 255); m_v = ovf8(sa + sb); end
            2: begin m_lo = (a - b) & 255; m_hi = (a < b); m_c = (a < b); m_v = ovf8(sa - sb); end
            3: begin m_lo = a & b; m_hi = 0; end
            4: begin m_lo = a | b; m_hi = 0; end
            5: begin m_lo = a ^ b; m_hi = 0; end
            6: begin m_lo = (~a) & 255; m_hi = 0; end
            7: begin m_lo = (a << sh) & 255; m_hi = 0; m_c = (sh != 0) && (((a >> (8 - sh)) & 1) == 1); end
            8: begin m_lo = a >> sh; m_hi = 0; m_c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            9: begin m_lo = (sa >>> sh) & 255; m_hi = 0; m_c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            10: begin r = a * b; m_lo = r & 255; m_hi = r >> 8; m_c = (m_hi != 0); end
            11: begin
                if (b == 0) begin m_lo = 255; m_hi = a; m_err = 1; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            12: begin fsrc = (a - b) & 255; m_c = (a < b); m_v = ovf8(sa - sb); end
            default: begin m_err = 1; zn = 0; end
        endcase
        if (op != 12) fsrc = m_lo;
        m_z = zn && (fsrc == 0);
        m_n = zn && (((fsrc >> 7) & 1) == 1);
        m_done = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        w_addr = 8'(addr);
        tb_d   = 8'(data);
        tb_en  = 1'b1;
        tick();
        w_addr = 8'h00;
        tb_en  = 1'b0;
    endtask

    task automatic rd(input int addr, output int data);
        r_addr = 8'(addr);
        #1;
        data   = int'(bus);
        r_addr = 8'h00;
    endtask

    task automatic set_ab(input int a, input int b);
        wr(BASE + 0, a); m_a = a;
        wr(BASE + 1, b); m_b = b;
    endtask

    // Poll STATUS until busy drops; returns edges waited after the accepting edge
    task automatic wait_idle(output int cycles);
        int s;
        cycles = 0;
        rd(BASE + 5, s);
        while ((s & 1) == 1 && cycles < 20) begin
            tick();
            cycles++;
            rd(BASE + 5, s);
        end
    endtask

    task automatic check_all(input string tag);
        int v;
        rd(BASE + 0, v); check_eq({tag, "_a"}, v, m_a);
        rd(BASE + 1, v); check_eq({tag, "_b"}, v, m_b);
        rd(BASE + 3, v); check_eq({tag, "_lo"}, v, m_lo);
        rd(BASE + 4, v); check_eq({tag, "_hi"}, v, m_hi);
        rd(BASE + 5, v); check_eq({tag, "_st"}, v, exp_status());
    endtask

    int v, cyc;

    initial begin
        rst = 1'b1; r_addr = 8'h00; w_addr = 8'h00; tb_en = 1'b0; tb_d = 8'h00;
        model_reset();
        tick(); tick();
        rd(BASE + 5, v); check_eq("rst_bus_z", v, 32'hFF);
        rst = 1'b0;
        tick();
        check_all("reset");

        // Reset asserted mid-MUL
        set_ab(3, 5);
        wr(BASE + 2, 10);
        tick(); tick();
        rst = 1'b1;
        #1;
        rd(BASE + 5, v); check_eq("t1_bus_z", v, 32'hFF);
        tick();
        rst = 1'b0;
        model_reset();
        check_all("t1_post");
        for (int i = 0; i < 12; i++) tick();
        rd(BASE + 5, v); check_eq("t1_no_done", v, 32'h00);

        // ADD with carry
        set_ab(8'hF0, 8'h20);
        wr(BASE + 2, 1); model_cmd(1);
        rd(BASE + 3, v); check_eq("t2_lo", v, 32'h10);
        rd(BASE + 4, v); check_eq("t2_hi", v, 32'h01);
        rd(BASE + 5, v); check_eq("t2_st", v, 32'h12);

        // MUL: busy for DATA_W edges, operand writes ignored meanwhile
        set_ab(8'h0D, 8'h0B);
        wr(BASE + 2, 10); model_cmd(10);
        for (int i = 0; i < W; i++) begin
            rd(BASE + 5, v); check_eq("t3_busy", v & 1, 1);
            if (i == 3) wr(BASE + 0, 8'h55);
            else tick();
        end
        rd(BASE + 3, v); check_eq("t3_lo", v, 32'h8F);
        rd(BASE + 4, v); check_eq("t3_hi", v, 32'h00);
        rd(BASE + 5, v); check_eq("t3_st", v, 32'h22);
        rd(BASE + 0, v); check_eq("t3_a_kept", v, 32'h0D);

        // DIV then divide by zero
        set_ab(8'h64, 8'h07);
        wr(BASE + 2, 11); model_cmd(11);
        wait_idle(cyc); check_eq("t4_lat", cyc, W);
        rd(BASE + 3, v); check_eq("t4_lo", v, 32'h0E);
        rd(BASE + 4, v); check_eq("t4_hi", v, 32'h02);
        set_ab(8'h64, 8'h00);
        wr(BASE + 2, 11); model_cmd(11);
        rd(BASE + 5, v); check_eq("t4_dz_busy", v & 1, 0);
        rd(BASE + 5, v); check_eq("t4_dz_err", (v >> 2) & 1, 1);
        rd(BASE + 3, v); check_eq("t4_dz_lo", v, 32'hFF);
        rd(BASE + 4, v); check_eq("t4_dz_hi", v, 32'h64);

        // CMD write while busy, then illegal opcode
        set_ab(8'h0D, 8'h0B);
        wr(BASE + 2, 10); model_cmd(10);
        tick(); tick();
        wr(BASE + 2, 1); m_err = 1;
        for (int i = 0; i < 5; i++) tick();
        check_all("t5_mul");
        rd(BASE + 5, v); check_eq("t5_err", (v >> 2) & 1, 1);
        wr(BASE + 2, 8'h0F); model_cmd(15);
        rd(BASE + 5, v); check_eq("t5_ill_st", v, 32'h06);
        check_all("t5_ill");

        // CMP, window edges, write-ignored registers
        set_ab(8'h80, 8'h01);
        wr(BASE + 2, 12); model_cmd(12);
        rd(BASE + 5, v); check_eq("t6_cmp_st", v, 32'h42);
        check_all("t6_cmp");
        rd(8'h00, v); check_eq("t6_addr0_z", v, 32'hFF);
        rd(8'h20, v); check_eq("t6_addr20_z", v, 32'hFF);
        rd(8'h16, v); check_eq("t6_addr16_z", v, 32'hFF);
        rd(BASE + 2, v); check_eq("t6_cmd_rd0", v, 32'h00);
        wr(BASE + 3, 8'h55); wr(BASE + 5, 8'h55); wr(8'h16, 8'h55); wr(8'h0F, 8'h55);
        check_all("t6_ro");

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            int a, b, op;
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            op = int'($urandom_range(1, 15));
            set_ab(a, b);
            wr(BASE + 2, op);
            if (is_iter(op)) begin
                model_cmd(op);
                wait_idle(cyc); check_eq($sformatf("rnd%0d_lat", i), cyc, W);
            end else begin
                model_cmd(op);
            end
            check_all($sformatf("rnd%0d_op%0d", i, op));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
